// File: rtl/rgb_sbit2wrd_gen_if.sv
// Bus between the serial-bit decoder, the word assembler and the downstream
// FIFO/converter: decoded-bit strobes in, status+pixel words out over valid/ready.
interface rgb_sbit2wrd_gen_if #(
  parameter int BITS_PER_PIXEL = 24,
  parameter int PIX_IDX_W      = 10
);
  logic                        in_strobe;
  logic                        in_sbit_value;
  logic                        in_stream_reset;
  logic                        out_ready;
  logic [BITS_PER_PIXEL+7:0]   out_word;
  logic                        out_valid;
  logic [PIX_IDX_W-1:0]        out_pix_idx;
  logic                        frame_done;
  logic                        overrun;

  modport slave (
    input  in_strobe, in_sbit_value, in_stream_reset, out_ready,
    output out_word, out_valid, out_pix_idx, frame_done, overrun
  );

  modport master (
    output in_strobe, in_sbit_value, in_stream_reset, out_ready,
    input  out_word, out_valid, out_pix_idx, frame_done, overrun
  );
endinterface

// File: rtl/rgb_sbit2wrd_gen.sv
// Packs decoded WS2812b bits MSB-first into 24/32-bit pixel words and hands
// them downstream with a status byte, pixel index, frame pulse and overrun flag.
module rgb_sbit2wrd_gen #(
  parameter int BITS_PER_PIXEL = 24,
  parameter int PIX_IDX_W      = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  rgb_sbit2wrd_gen_if.slave bus
);
  localparam int              BC_W   = $clog2(BITS_PER_PIXEL);
  localparam logic [BC_W-1:0] BC_TOP = BC_W'(BITS_PER_PIXEL - 1);
  localparam int              WORD_W = BITS_PER_PIXEL + 8;
  localparam int              SR_BIT = BITS_PER_PIXEL + 6;

  if (BITS_PER_PIXEL != 24 && BITS_PER_PIXEL != 32) begin : g_bpp_check
    $error("rgb_sbit2wrd_gen: BITS_PER_PIXEL must be 24 or 32");
  end

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t                    r_state;
  logic [1:0]                r_rst_sync;
  logic                      r_strobe_d;
  logic [BC_W-1:0]           r_bcount;
  logic [BITS_PER_PIXEL-1:0] r_data;
  logic [WORD_W-1:0]         r_word;
  logic                      r_valid;
  logic [PIX_IDX_W-1:0]      r_idx;
  logic [PIX_IDX_W-1:0]      r_pix;
  logic                      r_frame_done;
  logic                      r_overrun;

  logic                      w_run;
  logic                      w_event;
  logic                      w_last_bit;
  logic                      w_emit;
  logic                      w_accept;
  logic                      w_drop;
  logic                      w_acc_sr;
  logic                      w_partial;
  logic [7:0]                w_status;
  logic [BITS_PER_PIXEL-1:0] w_new_data;
  logic [PIX_IDX_W-1:0]      w_pix_after;

  function automatic logic [PIX_IDX_W-1:0] sat_inc(input logic [PIX_IDX_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    w_run      = r_rst_sync[1];
    w_event    = w_run && bus.in_strobe && !r_strobe_d;
    w_last_bit = (r_bcount == '0);
    w_emit     = w_event && (bus.in_stream_reset || w_last_bit);
    w_accept   = r_valid && bus.out_ready;
    w_drop     = w_emit && r_valid && !bus.out_ready;
    w_acc_sr   = w_accept && r_word[SR_BIT];
    w_partial  = bus.in_stream_reset && (r_bcount != BC_TOP);
    w_status   = {1'b1, bus.in_stream_reset, w_partial, r_overrun, 4'b0000};
    // The final data bit lands in bit 0 of the word being emitted this cycle
    w_new_data = bus.in_stream_reset ? r_data
                                     : {r_data[BITS_PER_PIXEL-1:1], bus.in_sbit_value};
    // Index seen by a word emitted now already accounts for a same-cycle accept
    w_pix_after = r_pix;
    if (w_accept) begin
      w_pix_after = w_acc_sr ? '0 : sat_inc(r_pix);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync   <= 2'b00;
      r_strobe_d   <= 1'b0;
      r_bcount     <= BC_TOP;
      r_data       <= '0;
      r_word       <= '0;
      r_valid      <= 1'b0;
      r_idx        <= '0;
      r_pix        <= '0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
      r_state      <= COLLECT;
    end else begin
      r_rst_sync   <= {r_rst_sync[0], 1'b1};
      r_strobe_d   <= bus.in_strobe;
      r_frame_done <= w_acc_sr;
      // A dropped stream-reset word still realigns the frame
      r_pix        <= (w_drop && bus.in_stream_reset) ? '0 : w_pix_after;
      if (w_drop) begin
        r_overrun <= 1'b1;
      end

      if (w_event) begin
        if (bus.in_stream_reset || w_last_bit) begin
          r_bcount <= BC_TOP;
          r_data   <= '0;
        end else begin
          r_data[r_bcount] <= bus.in_sbit_value;
          r_bcount         <= r_bcount - 1'b1;
        end
      end

      case (r_state)
        COLLECT: begin
          if (w_emit) begin
            r_word  <= {w_status, w_new_data};
            r_idx   <= w_pix_after;
            r_valid <= 1'b1;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (w_accept) begin
            if (w_emit) begin
              r_word <= {w_status, w_new_data};
              r_idx  <= w_pix_after;
            end else begin
              r_valid <= 1'b0;
              r_state <= COLLECT;
            end
          end
        end
      endcase
    end
  end

  assign bus.out_word    = r_word;
  assign bus.out_valid   = r_valid;
  assign bus.out_pix_idx = r_idx;
  assign bus.frame_done  = r_frame_done;
  assign bus.overrun     = r_overrun;
endmodule

// File: tb/tb_rgb_sbit2wrd_gen.sv
// Bench for rgb_sbit2wrd_gen: a 24-bit and a 32-bit instance share one stimulus
// stream and are compared each cycle against a bit-count/accumulator model.
module tb_rgb_sbit2wrd_gen;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic s_strobe = 1'b0;
  logic s_bit    = 1'b0;
  logic s_sr     = 1'b0;
  logic rdy      = 1'b1;

  always #5 clk = ~clk;

  rgb_sbit2wrd_gen_if #(.BITS_PER_PIXEL(24), .PIX_IDX_W(10)) if24 ();
  rgb_sbit2wrd_gen_if #(.BITS_PER_PIXEL(32), .PIX_IDX_W(2))  if32 ();

  assign if24.in_strobe       = s_strobe;
  assign if24.in_sbit_value   = s_bit;
  assign if24.in_stream_reset = s_sr;
  assign if24.out_ready       = rdy;
  assign if32.in_strobe       = s_strobe;
  assign if32.in_sbit_value   = s_bit;
  assign if32.in_stream_reset = s_sr;
  assign if32.out_ready       = rdy;

  rgb_sbit2wrd_gen #(.BITS_PER_PIXEL(24), .PIX_IDX_W(10)) u24 (
    .clk(clk), .rst_n(rst_n), .bus(if24.slave)
  );
  rgb_sbit2wrd_gen #(.BITS_PER_PIXEL(32), .PIX_IDX_W(2)) u32 (
    .clk(clk), .rst_n(rst_n), .bus(if32.slave)
  );

  int n_tot = 0;
  int n_bad = 0;

  // Reference model state, index 0 = 24-bit instance, 1 = 32-bit instance
  int     bpp[2] = '{24, 32};
  int     iw[2]  = '{10, 2};
  longint m_acc[2];
  longint m_word[2];
  int     m_n[2];
  int     m_idx[2];
  int     m_pix[2];
  int     m_rel[2];
  bit     m_vld[2];
  bit     m_ovr[2];
  bit     m_fd[2];
  bit     m_prev[2];

  logic [63:0] lw24[$];
  logic [63:0] li24[$];
  logic [63:0] lw32[$];
  logic [63:0] li32[$];
  int vcnt[2];
  int fdcnt[2];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic void mdl_reset(input int m);
    m_acc[m] = 0; m_word[m] = 0; m_n[m] = 0; m_idx[m] = 0; m_pix[m] = 0;
    m_rel[m] = 0; m_vld[m] = 1'b0; m_ovr[m] = 1'b0; m_fd[m] = 1'b0; m_prev[m] = 1'b0;
  endfunction

  // Advances the model by one clock edge using the inputs the DUT will sample
  function automatic void mdl_step(input int m);
    int     b;
    bit     ev, acc, is_sr, emit;
    longint st, dat;
    b = bpp[m];
    st = 0; dat = 0; emit = 1'b0; is_sr = 1'b0;
    if (!rst_n) begin
      mdl_reset(m);
      return;
    end
    ev  = (m_rel[m] >= 2) && s_strobe && !m_prev[m];
    acc = m_vld[m] && rdy;
    m_fd[m] = acc && (((m_word[m] >> (b + 6)) & 1) == 1);
    if (acc) begin
      if (m_fd[m]) m_pix[m] = 0;
      else if (m_pix[m] < (1 << iw[m]) - 1) m_pix[m] = m_pix[m] + 1;
    end
    if (ev && s_sr) begin
      st = 64'hC0;
      if (m_n[m] > 0) st = st | 64'h20;
      if (m_ovr[m]) st = st | 64'h10;
      dat = m_acc[m] << (b - m_n[m]);
      emit = 1'b1; is_sr = 1'b1;
      m_acc[m] = 0; m_n[m] = 0;
    end else if (ev) begin
      m_acc[m] = m_acc[m] * 2 + longint'(s_bit);
      m_n[m]++;
      if (m_n[m] == b) begin
        st = m_ovr[m] ? 64'h90 : 64'h80;
        dat = m_acc[m];
        emit = 1'b1;
        m_acc[m] = 0; m_n[m] = 0;
      end
    end
    if (emit) begin
      if (m_vld[m] && !acc) begin
        m_ovr[m] = 1'b1;
        if (is_sr) m_pix[m] = 0;
      end else begin
        m_word[m] = (st << b) | dat;
        m_idx[m]  = m_pix[m];
        m_vld[m]  = 1'b1;
      end
    end else if (acc) begin
      m_vld[m] = 1'b0;
    end
    m_prev[m] = s_strobe;
    if (m_rel[m] < 2) m_rel[m]++;
  endfunction

  task automatic cyc(input bit s, input bit b, input bit sr);
    s_strobe = s; s_bit = b; s_sr = sr;
    if (if24.out_valid && rdy) begin
      lw24.push_back(64'(if24.out_word)); li24.push_back(64'(if24.out_pix_idx));
    end
    if (if32.out_valid && rdy) begin
      lw32.push_back(64'(if32.out_word)); li32.push_back(64'(if32.out_pix_idx));
    end
    mdl_step(0);
    mdl_step(1);
    @(negedge clk);
    chk("vld24",  64'(if24.out_valid),   64'(m_vld[0]));
    chk("word24", 64'(if24.out_word),    64'(m_word[0]));
    chk("idx24",  64'(if24.out_pix_idx), 64'(m_idx[0]));
    chk("fd24",   64'(if24.frame_done),  64'(m_fd[0]));
    chk("ovr24",  64'(if24.overrun),     64'(m_ovr[0]));
    chk("vld32",  64'(if32.out_valid),   64'(m_vld[1]));
    chk("word32", 64'(if32.out_word),    64'(m_word[1]));
    chk("idx32",  64'(if32.out_pix_idx), 64'(m_idx[1]));
    chk("fd32",   64'(if32.frame_done),  64'(m_fd[1]));
    chk("ovr32",  64'(if32.overrun),     64'(m_ovr[1]));
    if (if24.out_valid)  vcnt[0]++;
    if (if32.out_valid)  vcnt[1]++;
    if (if24.frame_done) fdcnt[0]++;
    if (if32.frame_done) fdcnt[1]++;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_bit(input bit b, input int hold);
    repeat (hold) cyc(1'b1, b, 1'b0);
    cyc(1'b0, b, 1'b0);
  endtask

  task automatic send_word(input longint v, input int nb, input int hold);
    for (int i = nb - 1; i >= 0; i--) send_bit(bit'((v >> i) & 1), hold);
  endtask

  task automatic send_sr();
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic clr_logs();
    lw24.delete(); li24.delete(); lw32.delete(); li32.delete();
    vcnt[0] = 0; vcnt[1] = 0; fdcnt[0] = 0; fdcnt[1] = 0;
  endtask

  // Reset is applied just after a falling edge so the async clear is visible before the next rise
  task automatic do_reset();
    rst_n = 1'b0; s_strobe = 1'b0; s_bit = 1'b0; s_sr = 1'b0;
    #1;
    mdl_reset(0);
    mdl_reset(1);
    chk("rst_vld24",  64'(if24.out_valid),   64'd0);
    chk("rst_word24", 64'(if24.out_word),    64'd0);
    chk("rst_idx24",  64'(if24.out_pix_idx), 64'd0);
    chk("rst_fd24",   64'(if24.frame_done),  64'd0);
    chk("rst_ovr24",  64'(if24.overrun),     64'd0);
    chk("rst_vld32",  64'(if32.out_valid),   64'd0);
    chk("rst_word32", 64'(if32.out_word),    64'd0);
    chk("rst_ovr32",  64'(if32.overrun),     64'd0);
    idle(2);
    rst_n = 1'b1;
    idle(4);
  endtask

  function automatic logic [63:0] lget(input int m, input int i, input bit want_idx);
    if (m == 0) begin
      if (i >= lw24.size()) return 64'hFFFF_FFFF_FFFF_FFFF;
      return want_idx ? li24[i] : lw24[i];
    end
    if (i >= lw32.size()) return 64'hFFFF_FFFF_FFFF_FFFF;
    return want_idx ? li32[i] : lw32[i];
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mdl_reset(0);
    mdl_reset(1);
    clr_logs();
    @(negedge clk);
    do_reset();

    // Single 24-bit pixel, one valid cycle, index 0
    clr_logs();
    rdy = 1'b1;
    send_word(64'hA5C3F0, 24, 1);
    idle(3);
    chk("t1_count", 64'(lw24.size()), 64'd1);
    chk("t1_word",  lget(0, 0, 1'b0), 64'h80A5C3F0);
    chk("t1_idx",   lget(0, 0, 1'b1), 64'd0);
    chk("t1_vcyc",  64'(vcnt[0]),     64'd1);

    // Two 32-bit pixels then a stream reset, then a fresh frame
    do_reset();
    clr_logs();
    send_word(64'h11223344, 32, 1);
    send_word(64'h55667788, 32, 1);
    send_sr();
    idle(3);
    chk("t2_count", 64'(lw32.size()), 64'd3);
    chk("t2_w0",    lget(1, 0, 1'b0), 64'h80_1122_3344);
    chk("t2_i0",    lget(1, 0, 1'b1), 64'd0);
    chk("t2_w1",    lget(1, 1, 1'b0), 64'h80_5566_7788);
    chk("t2_i1",    lget(1, 1, 1'b1), 64'd1);
    chk("t2_w2",    lget(1, 2, 1'b0), 64'hC0_0000_0000);
    chk("t2_i2",    lget(1, 2, 1'b1), 64'd2);
    chk("t2_fd",    64'(fdcnt[1]),    64'd1);
    send_word(64'hDEADBEEF, 32, 1);
    idle(3);
    chk("t2_w3",    lget(1, 3, 1'b0), 64'h80_DEAD_BEEF);
    chk("t2_i3",    lget(1, 3, 1'b1), 64'd0);

    // Partial pixel flushed by a stream reset
    do_reset();
    clr_logs();
    send_word(64'hFF, 8, 1);
    send_sr();
    idle(3);
    chk("t3_count", 64'(lw24.size()), 64'd1);
    chk("t3_word",  lget(0, 0, 1'b0), 64'hE0FF0000);

    // Back-pressure: second pixel dropped, overrun flagged in the next word
    do_reset();
    clr_logs();
    rdy = 1'b0;
    send_word(64'h123456, 24, 1);
    send_word(64'h654321, 24, 1);
    idle(2);
    chk("t4_hold",  64'(if24.out_word),  64'h80123456);
    chk("t4_vld",   64'(if24.out_valid), 64'd1);
    chk("t4_ovr",   64'(if24.overrun),   64'd1);
    rdy = 1'b1;
    idle(2);
    send_word(64'h000001, 24, 1);
    idle(3);
    chk("t4_count", 64'(lw24.size()), 64'd2);
    chk("t4_w0",    lget(0, 0, 1'b0), 64'h80123456);
    chk("t4_w1",    lget(0, 1, 1'b0), 64'h90000001);
    chk("t4_i1",    lget(0, 1, 1'b1), 64'd1);

    // Long strobes, then reset in the middle of a word while a word is held
    do_reset();
    clr_logs();
    rdy = 1'b0;
    send_word(64'h0F0F0F, 24, 5);
    send_word(64'h00FF00, 24, 5);
    send_word(64'hABC, 12, 5);
    do_reset();
    clr_logs();
    rdy = 1'b1;
    send_word(64'h3C5A96, 24, 5);
    idle(3);
    chk("t5_count", 64'(lw24.size()), 64'd1);
    chk("t5_word",  lget(0, 0, 1'b0), 64'h803C5A96);
    chk("t5_idx",   lget(0, 0, 1'b1), 64'd0);

    // Random strobes, bits, stream resets and ready bursts
    do_reset();
    rdy = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      if (i == 3000) do_reset();
      if ($urandom_range(0, 99) == 0) rdy = ~rdy;
      cyc(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
          $urandom_range(0, 199) == 0);
    end
    rdy = 1'b1;
    idle(4);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule

// File: doc/rgb_sbit2wrd_gen.md
Name: rgb_sbit2wrd_gen

Overview:
- Parametrised successor to the fixed 24-bit serial-bit-to-word assembler.
- Collects WS2812b-style decoded bits (strobe, bit value, stream reset) from the serial input block. Packs them MSB-first into pixel words of BITS_PER_PIXEL bits: 24 for GRB, 32 for GRBW.
- Emits each word with an 8-bit status byte over a valid/ready handshake to the downstream FIFO or RGBW converter.
- Adds partial-pixel flush, a pixel index, overrun detection and an end-of-frame pulse.

Parameters:
BITS_PER_PIXEL, 24, data bits per pixel; legal values 24 or 32; any other value is an elaboration error.
PIX_IDX_W, 10, width of the pixel index counter.

Ports:
clk  in  1  system clock, 96 MHz.
rst_n  in  1  asynchronous active-low reset.
in_strobe  in  1  high for ≥1 clock per event; only the rising edge is acted on.
in_sbit_value  in  1  bit value; meaningful at the strobe rising edge when in_stream_reset=0.
in_stream_reset  in  1  at the strobe rising edge: 1 = 50 µs stream reset detected.
out_ready  in  1  downstream accepts out_word when out_valid && out_ready.
out_word  out  BITS_PER_PIXEL+8  {status[7:0], data[BITS_PER_PIXEL-1:0]}.
out_valid  out  1  out_word holds an unaccepted word.
out_pix_idx  out  PIX_IDX_W  index of the pixel in out_word within the current frame.
frame_done  out  1  one-clock pulse when a stream-reset word is accepted.
overrun  out  1  sticky; set when a word is dropped; cleared only by reset.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - out_word=0, out_valid=0, out_pix_idx=0, frame_done=0, overrun=0.
  - Bit counter = BITS_PER_PIXEL-1, shift data = 0, pixel counter = 0, strobe edge register = 0.
  - Reset assertion mid-word or mid-handshake discards everything.
  - Deassertion is synchronised by a 2-flop synchroniser; the block ignores strobes until the synchroniser releases.
- Edge detect: event = in_strobe && !strobe_d (strobe_d registered). A strobe held for N clocks yields exactly one event.
- Status byte:
  - bit7 valid: always 1 in an emitted word.
  - bit6 stream_reset.
  - bit5 partial.
  - bit4 overrun_at_emit: copy of the overrun flag at emit time.
  - bits3:0 = 0.
- Data event (in_stream_reset=0):
  - Write in_sbit_value into data[bcount].
  - If bcount != 0: decrement bcount.
  - Else: complete the pixel, emit word {8'b1000_0000 | ovr, data}, then reset bcount to BITS_PER_PIXEL-1 and clear the shift data.
- Stream-reset event:
  - If bcount == BITS_PER_PIXEL-1 (no bits pending): emit a word with data=0, bit6=1, bit5=0.
  - Else: emit a word with the bits received so far, unreceived LSBs = 0, bit6=1, bit5=1.
  - In both cases bcount is restored.
- Emit timing: an event sampled on cycle N produces out_valid=1 and out_word on cycle N+1 (1-cycle latency).
- out_pix_idx:
  - Emitted with each word; equals the count of data words emitted since the last stream-reset word.
  - Increments after each accepted data word; saturates at all-ones with no wrap.
  - A stream-reset word carries the current index, then the counter clears to 0 on acceptance.
- Handshake:
  - out_word/out_pix_idx are stable while out_valid && !out_ready.
  - out_valid drops the cycle after acceptance unless a new word is emitted that same cycle.
  - Acceptance and a new emit in the same cycle: the new word replaces the old with out_valid held at 1 (no bubble).
- Overrun: a word completes while out_valid && !out_ready.
  - The new word is dropped; the old word is kept.
  - overrun is set; the next emitted word has status bit4=1.
  - Exception: a dropped stream-reset word still clears the pixel counter and bcount, so frame alignment is preserved.
- frame_done: 1-cycle pulse on the cycle after acceptance of a word with bit6=1.
- FSM states:
  - COLLECT: no pending output.
  - HOLD: out_valid=1, waiting for ready.
  - Transitions: COLLECT→HOLD on emit; HOLD→COLLECT on accept without a new emit; HOLD→HOLD on accept with a simultaneous emit, or on drop.

Test Plan:
- Reset then 24 strobes (BITS_PER_PIXEL=24) with bits 0xA5C3F0 MSB-first, out_ready=1 → one word 0x80A5C3F0, out_pix_idx=0, out_valid high 1 cycle, 1 cycle after the 24th edge.
- BITS_PER_PIXEL=32, two pixels 0x11223344 and 0x55667788, then a stream reset → words 0x8011223344 (idx 0), 0x8055667788 (idx 1), 0xC000000000 (idx 2); frame_done pulses once; the next pixel gets idx 0.
- 24-bit, 8 bits 0xFF then a stream reset → 0xE0FF0000 (partial flag set).
- out_ready=0 held, two full pixels sent → first word held stable, second dropped, overrun=1. Then ready=1 and a third pixel 0x000001 → 0x90000001.
- in_strobe held 5 clocks per bit → exactly one bit consumed per strobe; rst_n pulsed low after 12 bits → all outputs 0 immediately; the next 24 bits form a clean word with idx 0.
